axil_single_master: RTL



---
 rtl/axil_single_master.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/axil_single_master.sv
// axil_single_master
//   AXI-lite initiator: turns a one-command-at-a-time request port into a
//   single AXI-lite read or write, then returns one response beat.
//   Only one transaction is ever outstanding.
// Ports
//   i_clk, i_reset       : clock, synchronous active-high reset
//   i_cmd_*/o_cmd_ready  : command request (we, addr, data, strb)
//   o_rsp_*/i_rsp_ready  : response beat (we echo, read data, resp code)
//   M_AXI_AW*/W*/B*      : AXI-lite write channels
//   M_AXI_AR*/R*         : AXI-lite read channels
module axil_single_master #(
  parameter int C_AXI_ADDR_WIDTH = 4,
  parameter bit OPT_LOWPOWER     = 1'b0
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_cmd_valid,
  output logic                        o_cmd_ready,
  input  logic                        i_cmd_we,
  input  logic [C_AXI_ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [31:0]                 i_cmd_data,
  input  logic [3:0]                  i_cmd_strb,
  output logic                        o_rsp_valid,
  input  logic                        i_rsp_ready,
  output logic                        o_rsp_we,
  output logic [31:0]                 o_rsp_data,
  output logic [1:0]                  o_rsp_resp,
  output logic                        M_AXI_AWVALID,
  input  logic                        M_AXI_AWREADY,
  output logic [C_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [2:0]                  M_AXI_AWPROT,
  output logic                        M_AXI_WVALID,
  input  logic                        M_AXI_WREADY,
  output logic [31:0]                 M_AXI_WDATA,
  output logic [3:0]                  M_AXI_WSTRB,
  input  logic                        M_AXI_BVALID,
  output logic                        M_AXI_BREADY,
  input  logic [1:0]                  M_AXI_BRESP,
  output logic                        M_AXI_ARVALID,
  input  logic                        M_AXI_ARREADY,
  output logic [C_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0]                  M_AXI_ARPROT,
  input  logic                        M_AXI_RVALID,
  output logic                        M_AXI_RREADY,
  input  logic [31:0]                 M_AXI_RDATA,
  input  logic [1:0]                  M_AXI_RRESP
);

  localparam int C_AXI_DATA_WIDTH = 32;

  // Clears the two byte-lane bits of the command address.
  localparam logic [C_AXI_ADDR_WIDTH-1:0] ADDR_MASK = {C_AXI_ADDR_WIDTH{1'b1}} << 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                        state_r;
  state_t                        next_state_s;
  logic [C_AXI_ADDR_WIDTH-1:0]   addr_r;
  logic [C_AXI_DATA_WIDTH-1:0]   data_r;
  logic [3:0]                    strb_r;
  logic                          awvalid_r;
  logic                          wvalid_r;
  logic                          arvalid_r;
  logic                          rsp_we_r;
  logic [C_AXI_DATA_WIDTH-1:0]   rsp_data_r;
  logic [1:0]                    rsp_resp_r;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode. BREADY/RREADY are high for the whole WRITE/READ
  // state, so a B or R valid seen there is already a completed handshake.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (i_cmd_valid) begin
          if (i_cmd_we) begin
            next_state_s = S_WRITE;
          end else begin
            next_state_s = S_READ;
          end
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_WRITE: begin
        if (M_AXI_BVALID) begin
          next_state_s = S_RESP;
        end else begin
          next_state_s = S_WRITE;
        end
      end
      S_READ: begin
        if (M_AXI_RVALID) begin
          next_state_s = S_RESP;
        end else begin
          next_state_s = S_READ;
        end
      end
      S_RESP: begin
        if (i_rsp_ready) begin
          next_state_s = S_IDLE;
        end else begin
          next_state_s = S_RESP;
        end
      end
      default: next_state_s = S_IDLE;
    endcase
  end

  // Command capture, per-channel valid tracking and response capture.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      addr_r     <= {C_AXI_ADDR_WIDTH{1'b0}};
      data_r     <= {C_AXI_DATA_WIDTH{1'b0}};
      strb_r     <= 4'h0;
      awvalid_r  <= 1'b0;
      wvalid_r   <= 1'b0;
      arvalid_r  <= 1'b0;
      rsp_we_r   <= 1'b0;
      rsp_data_r <= {C_AXI_DATA_WIDTH{1'b0}};
      rsp_resp_r <= 2'b00;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (i_cmd_valid) begin
            addr_r   <= i_cmd_addr & ADDR_MASK;
            rsp_we_r <= i_cmd_we;
            if (i_cmd_we) begin
              data_r    <= i_cmd_data;
              strb_r    <= i_cmd_strb;
              awvalid_r <= 1'b1;
              wvalid_r  <= 1'b1;
            end else begin
              arvalid_r <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (M_AXI_AWREADY) begin
            awvalid_r <= 1'b0;
          end
          if (M_AXI_WREADY) begin
            wvalid_r <= 1'b0;
          end
          // An early B (before AW/W finished) is still taken; any valid
          // left up is withdrawn so nothing is issued outside WRITE.
          if (M_AXI_BVALID) begin
            awvalid_r  <= 1'b0;
            wvalid_r   <= 1'b0;
            rsp_data_r <= {C_AXI_DATA_WIDTH{1'b0}};
            rsp_resp_r <= M_AXI_BRESP;
          end
        end
        S_READ: begin
          if (M_AXI_ARREADY || M_AXI_RVALID) begin
            arvalid_r <= 1'b0;
          end
          if (M_AXI_RVALID) begin
            rsp_data_r <= M_AXI_RDATA;
            rsp_resp_r <= M_AXI_RRESP;
          end
        end
        S_RESP: begin
          rsp_we_r <= rsp_we_r;
        end
        default: begin
          awvalid_r <= 1'b0;
          wvalid_r  <= 1'b0;
          arvalid_r <= 1'b0;
        end
      endcase
    end
  end

  // Handshake signals are pure state decodes; no input reaches an output.
  assign o_cmd_ready   = (state_r == S_IDLE);
  assign o_rsp_valid   = (state_r == S_RESP);
  assign M_AXI_BREADY  = (state_r == S_WRITE);
  assign M_AXI_RREADY  = (state_r == S_READ);
  assign M_AXI_AWVALID = awvalid_r;
  assign M_AXI_WVALID  = wvalid_r;
  assign M_AXI_ARVALID = arvalid_r;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign o_rsp_we      = rsp_we_r;

  // Low-power option zeroes each payload while its valid is low.
  assign M_AXI_AWADDR = (OPT_LOWPOWER && !awvalid_r) ? {C_AXI_ADDR_WIDTH{1'b0}} : addr_r;
  assign M_AXI_ARADDR = (OPT_LOWPOWER && !arvalid_r) ? {C_AXI_ADDR_WIDTH{1'b0}} : addr_r;
  assign M_AXI_WDATA  = (OPT_LOWPOWER && !wvalid_r)  ? {C_AXI_DATA_WIDTH{1'b0}} : data_r;
  assign M_AXI_WSTRB  = (OPT_LOWPOWER && !wvalid_r)  ? 4'h0 : strb_r;
  assign o_rsp_data   = (OPT_LOWPOWER && !o_rsp_valid) ? {C_AXI_DATA_WIDTH{1'b0}} : rsp_data_r;
  assign o_rsp_resp   = (OPT_LOWPOWER && !o_rsp_valid) ? 2'b00 : rsp_resp_r;

endmodule
